// File: rtl/dma_port_responder.sv
// rtl/dma_port_responder.sv - memory-side responder for one DMA read port and one DMA write port
module dma_port_responder #(
  parameter int BURST_LEN = 16,
  parameter int PACE      = 3,
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reads_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] ob_data,
  output logic              ob_we,
  input  logic              writes_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] ib_data,
  input  logic              ib_valid,
  output logic              ib_re,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int IW = $clog2(BURST_LEN) + 1;
  localparam int PW = 4;
  localparam logic [PW-1:0] PACE_RELOAD = PW'(PACE - 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(BURST_LEN - 1);
  localparam logic [IW-1:0] FULL_CNT    = IW'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, RD_BURST, RD_DRAIN, WR_BURST} state_t;

  state_t            state_q, state_d;
  logic              last_wr_q, last_wr_d;   // 1 = last grant went to the write port
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IW-1:0]     idx_q, idx_d;           // reads issued / words accepted
  logic [IW-1:0]     wcnt_q, wcnt_d;         // memory writes done
  logic [PW-1:0]     pace_q, pace_d;         // 0 = expired
  logic              rd_v_q, rd_v_d;         // mem_rdata valid this cycle
  logic              ob_we_q, ob_we_d;
  logic [DATA_W-1:0] ob_data_q, ob_data_d;
  logic              wr_pend_q, wr_pend_d;   // captured word to write this cycle
  logic [DATA_W-1:0] wbuf_q, wbuf_d;

  assign ob_we   = ob_we_q;
  assign ob_data = ob_data_q;
  assign busy    = (state_q != IDLE);

  // Arbitration, burst sequencing, memory strobes and inbound pops
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    base_d    = base_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    pace_d    = pace_q;
    rd_v_d    = 1'b0;
    wr_pend_d = 1'b0;
    wbuf_d    = wbuf_q;
    ob_we_d   = rd_v_q;
    ob_data_d = rd_v_q ? mem_rdata : ob_data_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ib_re     = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d  = '0;
        wcnt_d = '0;
        pace_d = '0;
        if (reads_en && (!writes_en || last_wr_q)) begin
          state_d   = RD_BURST;
          last_wr_d = 1'b0;
          base_d    = rd_addr;
        end else if (writes_en) begin
          state_d   = WR_BURST;
          last_wr_d = 1'b1;
          base_d    = wr_addr;
        end
      end
      RD_BURST: begin
        if (pace_q == '0) begin
          mem_en   = 1'b1;
          mem_addr = base_q + ADDR_W'(idx_q);
          rd_v_d   = 1'b1;
          pace_d   = PACE_RELOAD;
          if (idx_q == LAST_IDX) state_d = RD_DRAIN;
          else                   idx_d   = idx_q + IW'(1);
        end else begin
          pace_d = pace_q - PW'(1);
        end
      end
      RD_DRAIN: begin
        // Leave once the final word is on ob_data and nothing is still in flight
        if (ob_we_q && !rd_v_q) state_d = IDLE;
      end
      WR_BURST: begin
        if (wr_pend_q) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = base_q + ADDR_W'(wcnt_q);
          mem_wdata = wbuf_q;
          wcnt_d    = wcnt_q + IW'(1);
          if (wcnt_q == LAST_IDX) state_d = IDLE;
        end
        if (pace_q != '0) begin
          pace_d = pace_q - PW'(1);
        end else if (ib_valid && idx_q != FULL_CNT) begin
          ib_re     = 1'b1;
          wbuf_d    = ib_data;
          wr_pend_d = 1'b1;
          idx_d     = idx_q + IW'(1);
          pace_d    = PACE_RELOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any burst in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      base_q    <= '0;
      idx_q     <= '0;
      wcnt_q    <= '0;
      pace_q    <= '0;
      rd_v_q    <= 1'b0;
      ob_we_q   <= 1'b0;
      ob_data_q <= '0;
      wr_pend_q <= 1'b0;
      wbuf_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      pace_q    <= pace_d;
      rd_v_q    <= rd_v_d;
      ob_we_q   <= ob_we_d;
      ob_data_q <= ob_data_d;
      wr_pend_q <= wr_pend_d;
      wbuf_q    <= wbuf_d;
    end
  end

endmodule

// File: tb/tb_dma_port_responder.sv
// tb/tb_dma_port_responder.sv - scoreboard bench for dma_port_responder
module tb_dma_port_responder;
  localparam int BURST_LEN = 16;
  localparam int PACE      = 3;
  localparam int ADDR_W    = 30;
  localparam int DATA_W    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              reads_en = 1'b0, writes_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0, wr_addr = '0;
  logic [DATA_W-1:0] ob_data, ib_data, mem_wdata, mem_rdata;
  logic              ob_we, ib_valid, ib_re, mem_en, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;

  dma_port_responder #(.BURST_LEN(BURST_LEN), .PACE(PACE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .reads_en(reads_en), .rd_addr(rd_addr), .ob_data(ob_data),
    .ob_we(ob_we), .writes_en(writes_en), .wr_addr(wr_addr), .ib_data(ib_data),
    .ib_valid(ib_valid), .ib_re(ib_re), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DATA_W-1:0] data; int cyc; } exp_ob_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } exp_wr_t;
  typedef struct {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dbase;
    logic              preload;
    int                stall;
    int                span;
  } vec_t;

  exp_ob_t exp_ob[$];
  exp_wr_t exp_wr[$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  int checks = 0, errors = 0, cyc = 0, ibre_cnt = 0;
  int wr_k = 0, stall_at = 5, stall_left = 0;
  logic ib_on = 1'b0, in_write = 1'b0;
  logic [DATA_W-1:0] ib_base = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data valid exactly one cycle after the strobe
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : '0;
    else                   mem_rdata <= 16'hBAD0;
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
  end

  // Inbound FWFT source: advances after each accepted pop, optional stall after word stall_at
  initial begin
    logic acc;
    ib_valid = 1'b0;
    ib_data  = '0;
    forever begin
      @(negedge clk);
      acc = ib_re && ib_valid;
      @(posedge clk);
      #1;
      if (acc) wr_k++;
      if (ib_on && wr_k == stall_at && stall_left > 0) begin
        ib_valid = 1'b0;
        stall_left--;
      end else begin
        ib_valid = ib_on && (wr_k < BURST_LEN);
      end
      ib_data = 16'(ib_base + wr_k);
    end
  end

  // Output monitor: pops scoreboard entries as the DUT produces them
  always @(negedge clk) begin
    if (rst_n) begin
      if (ob_we) begin
        if (exp_ob.size() == 0) chk("ob_unexpected", 1, 0);
        else begin
          exp_ob_t e;
          e = exp_ob.pop_front();
          chk("ob_data", ob_data, e.data);
          if (e.cyc >= 0) chk("ob_cycle", cyc, e.cyc);
        end
      end
      if (mem_en && mem_we) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          exp_wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", mem_addr, w.addr);
          chk("wr_data", mem_wdata, w.data);
        end
      end
      if (in_write && mem_en) chk("no_read_in_write", mem_we, 1);
      if (ib_re) begin
        chk("ib_re_valid", ib_valid, 1);
        ibre_cnt++;
      end
    end
  end

  task automatic wait_busy(input logic lvl, input int limit, output int t);
    t = 0;
    while (busy !== lvl && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk(lvl ? "busy_rise_timeout" : "busy_fall_timeout", busy, lvl);
  endtask

  task automatic run_vec(input vec_t v);
    int g, t, ib0;
    logic [ADDR_W-1:0] a;
    ib0 = ibre_cnt;
    for (int i = 0; i < BURST_LEN; i++) begin
      a = v.addr + 30'(i);
      if (!v.is_write && v.preload) mem[a] = 16'(v.dbase + i);
    end
    if (v.is_write) begin
      ib_base = v.dbase; wr_k = 0; stall_left = v.stall; ib_on = 1'b1; in_write = 1'b1;
    end
    @(negedge clk);
    if (v.is_write) begin writes_en = 1'b1; wr_addr = v.addr; end
    else            begin reads_en  = 1'b1; rd_addr = v.addr; end
    wait_busy(1'b1, 10, t);
    g = cyc;
    for (int i = 0; i < BURST_LEN; i++) begin
      a = v.addr + 30'(i);
      if (v.is_write) exp_wr.push_back('{addr: a, data: 16'(v.dbase + i)});
      else exp_ob.push_back('{data: 16'(v.dbase + i), cyc: (v.span < 0) ? -1 : g + 2 + PACE * i});
    end
    reads_en = 1'b0; writes_en = 1'b0; rd_addr = '0; wr_addr = '0;
    wait_busy(1'b0, 400, t);
    if (v.span >= 0) chk("burst_span", cyc - g, v.span);
    chk("ob_queue_empty", exp_ob.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    if (v.is_write) chk("ib_re_count", ibre_cnt - ib0, BURST_LEN);
    ib_on = 1'b0; in_write = 1'b0;
  endtask

  initial begin
    vec_t vecs[7];
    int t, ib0;
    logic [ADDR_W-1:0] a;
    vecs[0] = '{is_write: 1'b0, addr: 30'h100,      dbase: 16'h3C00, preload: 1'b1, stall: 0,  span: 48};
    vecs[1] = '{is_write: 1'b1, addr: 30'h200,      dbase: 16'h4000, preload: 1'b0, stall: 0,  span: 47};
    vecs[2] = '{is_write: 1'b0, addr: 30'h3FFFFFF8, dbase: 16'h5000, preload: 1'b1, stall: 0,  span: 48};
    vecs[3] = '{is_write: 1'b1, addr: 30'h3FFFFFFC, dbase: 16'h6000, preload: 1'b0, stall: 0,  span: 47};
    vecs[4] = '{is_write: 1'b0, addr: 30'h200,      dbase: 16'h4000, preload: 1'b0, stall: 0,  span: 48};
    vecs[5] = '{is_write: 1'b1, addr: 30'h300,      dbase: 16'h7000, preload: 1'b0, stall: 10, span: -1};
    vecs[6] = '{is_write: 1'b0, addr: 30'h300,      dbase: 16'h7000, preload: 1'b0, stall: 0,  span: 48};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ob_we", ob_we, 0);
    chk("rst_ob_data", ob_data, 0);
    chk("rst_ib_re", ib_re, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous requests out of reset: read, one IDLE cycle, write, then read again
    for (int i = 0; i < BURST_LEN; i++) mem[30'h400 + 30'(i)] = 16'h1000 + 16'(i);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < BURST_LEN; i++) exp_ob.push_back('{data: 16'h1000 + 16'(i), cyc: -1});
    for (int i = 0; i < BURST_LEN; i++) exp_wr.push_back('{addr: 30'h500 + 30'(i), data: 16'h2000 + 16'(i)});
    ib_base = 16'h2000; wr_k = 0; stall_left = 0; ib_on = 1'b1;
    ib0 = ibre_cnt;
    @(negedge clk);
    reads_en = 1'b1; writes_en = 1'b1; rd_addr = 30'h400; wr_addr = 30'h500;
    wait_busy(1'b1, 10, t);
    chk("tie1_is_read", mem_en && !mem_we, 1);
    wait_busy(1'b0, 400, t);
    wait_busy(1'b1, 10, t);
    chk("tie_idle_gap_rw", t, 1);
    chk("tie2_is_write", ib_re, 1);
    wait_busy(1'b0, 400, t);
    wait_busy(1'b1, 10, t);
    chk("tie_idle_gap_wr", t, 1);
    chk("tie3_is_read", mem_en && !mem_we, 1);
    reads_en = 1'b0; writes_en = 1'b0;
    wait_busy(1'b0, 400, t);
    chk("tie_ob_queue_empty", exp_ob.size(), 0);
    chk("tie_wr_queue_empty", exp_wr.size(), 0);
    chk("tie_ib_re_count", ibre_cnt - ib0, BURST_LEN);
    ib_on = 1'b0;
    @(negedge clk);

    // Table of single bursts
    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // Reset asserted while word 7 of a read burst is being issued
    for (int i = 0; i < BURST_LEN; i++) mem[30'h600 + 30'(i)] = 16'h3000 + 16'(i);
    for (int i = 0; i < 7; i++) exp_ob.push_back('{data: 16'h3000 + 16'(i), cyc: -1});
    @(negedge clk);
    reads_en = 1'b1; rd_addr = 30'h600;
    wait_busy(1'b1, 10, t);
    reads_en = 1'b0;
    t = 0;
    while (!(mem_en && !mem_we && mem_addr == 30'h607) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_word7_reached", mem_addr, 30'h607);
    rst_n = 1'b0;
    #1;
    chk("midrst_ob_we", ob_we, 0);
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_queue", exp_ob.size(), 0);
    repeat (2) @(negedge clk);
    chk("midrst_held_ob_we", ob_we, 0);
    rst_n = 1'b1;
    for (int i = 0; i < BURST_LEN; i++) mem[30'h700 + 30'(i)] = 16'h3100 + 16'(i);
    run_vec('{is_write: 1'b0, addr: 30'h700, dbase: 16'h3100, preload: 1'b1, stall: 0, span: 48});

    repeat (5) @(negedge clk);
    chk("final_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
